// File: rtl/dag_pkg.sv
// dag_pkg: shared register-kind encoding and default widths for the data address generator
package dag_pkg;
    typedef enum logic [1:0] {DAG_I = 2'd0, DAG_M = 2'd1, DAG_L = 2'd2, DAG_B = 2'd3} dag_kind_e;
    localparam int DMA_SIZE_DEF = 16;
    localparam int DMD_SIZE_DEF = 16;
    localparam int NREG_DEF     = 4;
endpackage

// File: rtl/dag_circ_update.sv
// dag_circ_update: address and next-index computation for post/pre-modify with circular wrap
module dag_circ_update #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] l_i,
    input  logic [W-1:0] b_i,
    input  logic         pre_i,
    output logic [W-1:0] addr_o,
    output logic [W-1:0] i_new_o
);
    logic [W:0] sum;
    logic [W:0] top;
    logic [W:0] wrap;
    // One extra bit keeps the buffer-end compare exact; M is sign-extended into it
    always_comb begin
        sum     = {1'b0, i_i} + {m_i[W-1], m_i};
        top     = {1'b0, b_i} + {1'b0, l_i};
        wrap    = (l_i == '0)            ? sum :
                  (sum >= top)           ? sum - {1'b0, l_i} :
                  (sum < {1'b0, b_i})    ? sum + {1'b0, l_i} : sum;
        i_new_o = wrap[W-1:0];
        addr_o  = pre_i ? sum[W-1:0] : i_i;
    end
endmodule

// File: rtl/dm_dag.sv
// dm_dag: DAG register file plus the DM command, write-data and read-return pipeline
module dm_dag
    import dag_pkg::*;
#(
    parameter int  DMA_SIZE = DMA_SIZE_DEF,
    parameter int  DMD_SIZE = DMD_SIZE_DEF,
    parameter int  NREG     = NREG_DEF,
    localparam int IW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ureg_wr_en,
    input  logic [1:0]          ureg_wr_kind,
    input  logic [IW-1:0]       ureg_wr_idx,
    input  logic [DMA_SIZE-1:0] ureg_wr_data,
    input  logic                acc_req,
    input  logic                acc_wr,
    input  logic                acc_pre,
    input  logic [IW-1:0]       acc_i_idx,
    input  logic [IW-1:0]       acc_m_idx,
    input  logic [DMD_SIZE-1:0] acc_wdata,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt,
    output logic                rd_valid,
    output logic [DMD_SIZE-1:0] rd_data
);
    logic [DMA_SIZE-1:0] i_q [NREG];
    logic [DMA_SIZE-1:0] i_d [NREG];
    logic [DMA_SIZE-1:0] m_q [NREG];
    logic [DMA_SIZE-1:0] m_d [NREG];
    logic [DMA_SIZE-1:0] l_q [NREG];
    logic [DMA_SIZE-1:0] l_d [NREG];
    logic [DMA_SIZE-1:0] b_q [NREG];
    logic [DMA_SIZE-1:0] b_d [NREG];
    logic [DMA_SIZE-1:0] addr;
    logic [DMA_SIZE-1:0] i_new;
    logic                cslt_q, wrb_q, wr1_q, rd1_q, rd2_q, rd_valid_q;
    logic [DMA_SIZE-1:0] add_q;
    logic [DMD_SIZE-1:0] wd_q, bc_q, rd_data_q;

    dag_circ_update #(.W(DMA_SIZE)) u_circ (
        .i_i     (i_q[acc_i_idx]),
        .m_i     (m_q[acc_m_idx]),
        .l_i     (l_q[acc_i_idx]),
        .b_i     (b_q[acc_i_idx]),
        .pre_i   (acc_pre),
        .addr_o  (addr),
        .i_new_o (i_new)
    );

    // Next register state: post-modify update first, so a same-cycle user write to I (or B) overrides it
    always_comb begin
        i_d = i_q;
        m_d = m_q;
        l_d = l_q;
        b_d = b_q;
        if (acc_req && !acc_pre) i_d[acc_i_idx] = i_new;
        if (ureg_wr_en) begin
            if (ureg_wr_kind == DAG_I || ureg_wr_kind == DAG_B) i_d[ureg_wr_idx] = ureg_wr_data;
            if (ureg_wr_kind == DAG_M) m_d[ureg_wr_idx] = ureg_wr_data;
            if (ureg_wr_kind == DAG_L) l_d[ureg_wr_idx] = ureg_wr_data;
            if (ureg_wr_kind == DAG_B) b_d[ureg_wr_idx] = ureg_wr_data;
        end
    end

    // I/M/L/B register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q <= '{default: '0};
            m_q <= '{default: '0};
            l_q <= '{default: '0};
            b_q <= '{default: '0};
        end else begin
            i_q <= i_d;
            m_q <= m_d;
            l_q <= l_d;
            b_q <= b_d;
        end
    end

    // Command stage, write-data delay and read-return capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cslt_q     <= 1'b0;
            wrb_q      <= 1'b0;
            add_q      <= '0;
            wr1_q      <= 1'b0;
            wd_q       <= '0;
            rd1_q      <= 1'b0;
            rd2_q      <= 1'b0;
            bc_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cslt_q     <= acc_req;
            wrb_q      <= acc_req && acc_wr;
            add_q      <= acc_req ? addr : add_q;
            wr1_q      <= acc_req && acc_wr;
            wd_q       <= (acc_req && acc_wr) ? acc_wdata : wd_q;
            rd1_q      <= acc_req && !acc_wr;
            rd2_q      <= rd1_q;
            bc_q       <= wr1_q ? wd_q : bc_q;
            rd_valid_q <= rd2_q;
            rd_data_q  <= rd2_q ? dm_bc_dt : rd_data_q;
        end
    end

    assign ps_dm_cslt = cslt_q;
    assign ps_dm_wrb  = wrb_q;
    assign dg_dm_add  = add_q;
    assign bc_dt      = bc_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
endmodule
